// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the fetch/data memory arbiter.
// Everything here is imported by mem_arbiter and byte_merge.
package mem_arbiter_pkg;

    localparam int BE_WIDTH = 4;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic ZERO          = 1'b0;

    localparam logic [BE_WIDTH-1:0] BE_FULL = 4'b1111;
    localparam logic [BE_WIDTH-1:0] BE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ      = 2'd1,
        ST_RMW_READ  = 2'd2,
        ST_RMW_WRITE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // A write needs the read-modify-write path only when some, but not all, lanes are enabled.
    function automatic logic is_partial(input logic [BE_WIDTH-1:0] be);
        return (be != BE_FULL) && (be != BE_NONE);
    endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational lane merge: each lane takes store data when its enable is set,
// otherwise keeps the word read back from RAM.
module byte_merge
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [BE_WIDTH-1:0]   be,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] merged
);

    localparam int LANE_WIDTH = DATA_WIDTH / BE_WIDTH;

    generate
        for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
            assign merged[gi*LANE_WIDTH +: LANE_WIDTH] =
                be[gi] ? wdata[gi*LANE_WIDTH +: LANE_WIDTH]
                       : rdata[gi*LANE_WIDTH +: LANE_WIDTH];
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an instruction-fetch reader and a data port,
// with starvation protection for fetch and read-modify-write for partial stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [BE_WIDTH-1:0]   dm_be_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  busy_o
);

    localparam int                    SW         = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0]         STARVE_ONE = SW'(1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    state_e                  state_reg;
    owner_e                  owner_reg;
    logic [SW-1:0]           starve_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    we_reg;
    logic [BE_WIDTH-1:0]     be_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   merge_reg;
    logic [DATA_WIDTH-1:0]   merge_next;

    logic idle_active;
    logic if_wins;
    logic if_gnt;
    logic dm_gnt;
    logic if_rvalid;
    logic dm_rvalid;

    byte_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_byte_merge (
        .be     (be_reg),
        .wdata  (wdata_reg),
        .rdata  (ram_rdata_i),
        .merged (merge_next)
    );

    // Grants are only offered from IDLE and never while reset is held.
    assign idle_active = (state_reg == ST_IDLE) && !rst_i;
    assign if_wins     = if_req_i && (!dm_req_i || (starve_reg == STARVE_MAX));
    assign if_gnt      = idle_active && if_wins;
    assign dm_gnt      = idle_active && dm_req_i && !if_wins;

    assign if_rvalid = (state_reg == ST_READ) && (owner_reg == OWN_IF) && !rst_i;
    assign dm_rvalid = (state_reg == ST_READ) && (owner_reg == OWN_DM) && !rst_i
                       && (we_reg == WRITE_DISABLE);

    assign if_gnt_o    = if_gnt;
    assign dm_gnt_o    = dm_gnt;
    assign if_rvalid_o = if_rvalid;
    assign dm_rvalid_o = dm_rvalid;
    assign if_rdata_o  = if_rvalid ? ram_rdata_i : {DATA_WIDTH{ZERO}};
    assign dm_rdata_o  = dm_rvalid ? ram_rdata_i : {DATA_WIDTH{ZERO}};
    assign busy_o      = (state_reg != ST_IDLE);

    // RAM port: the grant cycle drives the live request, RMW_WRITE drives the latched merge.
    always_comb begin
        ram_addr_o  = {ADDR_WIDTH{ZERO}};
        ram_we_o    = WRITE_DISABLE;
        ram_wdata_o = {DATA_WIDTH{ZERO}};
        dm_done_o   = 1'b0;
        if (if_gnt) begin
            ram_addr_o = if_addr_i & ALIGN_MASK;
        end else if (dm_gnt) begin
            if (!dm_we_i) begin
                ram_addr_o = dm_addr_i & ALIGN_MASK;
            end else if (dm_be_i == BE_FULL) begin
                ram_addr_o  = dm_addr_i & ALIGN_MASK;
                ram_we_o    = WRITE_ENABLE;
                ram_wdata_o = dm_wdata_i;
                dm_done_o   = 1'b1;
            end else if (dm_be_i == BE_NONE) begin
                dm_done_o = 1'b1;
            end else begin
                ram_addr_o = dm_addr_i & ALIGN_MASK;
            end
        end else if ((state_reg == ST_RMW_WRITE) && !rst_i) begin
            ram_addr_o  = addr_reg & ALIGN_MASK;
            ram_we_o    = WRITE_ENABLE;
            ram_wdata_o = merge_reg;
            dm_done_o   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= OWN_IF;
            starve_reg <= {SW{ZERO}};
            addr_reg   <= {ADDR_WIDTH{ZERO}};
            we_reg     <= WRITE_DISABLE;
            be_reg     <= BE_NONE;
            wdata_reg  <= {DATA_WIDTH{ZERO}};
            merge_reg  <= {DATA_WIDTH{ZERO}};
        end else begin
            if (if_gnt) begin
                starve_reg <= {SW{ZERO}};
            end else if (if_req_i && (starve_reg != STARVE_MAX)) begin
                starve_reg <= starve_reg + STARVE_ONE;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (if_gnt) begin
                        owner_reg <= OWN_IF;
                        addr_reg  <= if_addr_i;
                        we_reg    <= WRITE_DISABLE;
                        be_reg    <= BE_NONE;
                        wdata_reg <= {DATA_WIDTH{ZERO}};
                        state_reg <= ST_READ;
                    end else if (dm_gnt) begin
                        owner_reg <= OWN_DM;
                        addr_reg  <= dm_addr_i;
                        we_reg    <= dm_we_i;
                        be_reg    <= dm_be_i;
                        wdata_reg <= dm_wdata_i;
                        if (!dm_we_i) begin
                            state_reg <= ST_READ;
                        end else if (is_partial(dm_be_i)) begin
                            state_reg <= ST_RMW_READ;
                        end
                    end
                end
                ST_READ: begin
                    state_reg <= ST_IDLE;
                end
                ST_RMW_READ: begin
                    merge_reg <= merge_next;
                    state_reg <= ST_RMW_WRITE;
                end
                ST_RMW_WRITE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM (one-cycle read latency).
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        dm_done_o;
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        busy_o;

    logic [31:0] mem [0:255];
    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_be_i     (dm_be_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_rvalid_o (dm_rvalid_o),
        .dm_rdata_o  (dm_rdata_o),
        .dm_done_o   (dm_done_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .busy_o      (busy_o)
    );

    always @(posedge clk_i) begin
        if (ram_we_o) mem[ram_addr_o[9:2]] <= ram_wdata_o;
        ram_rdata_i <= mem[ram_addr_o[9:2]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i   = 1'b0;
        if_addr_i  = 32'h0;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_be_i    = 4'b0000;
        dm_addr_i  = 32'h0;
        dm_wdata_i = 32'h0;
    endtask

    task automatic dm_drive(input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        dm_req_i   = 1'b1;
        dm_we_i    = we;
        dm_be_i    = be;
        dm_addr_i  = addr;
        dm_wdata_i = wdata;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h104 >> 2] = 32'hDEADBEEF;
        mem[32'h200 >> 2] = 32'h11223344;
        mem[32'h300 >> 2] = 32'h55667788;
        ram_rdata_i = 32'h0;
        idle_inputs();

        // Reset
        rst_i = 1'b1;
        #1;
        check("rst_ram_we_during", {63'h0, ram_we_o}, 64'h0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_ram_addr", {32'h0, ram_addr_o}, 64'h0);
        check("rst_dm_rdata", {32'h0, dm_rdata_o}, 64'h0);
        check("rst_gnts", {62'h0, if_gnt_o, dm_gnt_o}, 64'h0);
        $display("txn reset");

        // dm read of 0x104
        dm_drive(1'b0, 4'b0000, 32'h104, 32'h0);
        #1;
        check("rd_gnt", {63'h0, dm_gnt_o}, 64'h1);
        check("rd_ram_addr", {32'h0, ram_addr_o}, 64'h104);
        check("rd_ram_we", {63'h0, ram_we_o}, 64'h0);
        check("rd_rvalid_T", {63'h0, dm_rvalid_o}, 64'h0);
        tick();
        idle_inputs();
        #1;
        check("rd_rvalid_T1", {63'h0, dm_rvalid_o}, 64'h1);
        check("rd_rdata_T1", {32'h0, dm_rdata_o}, 64'hDEADBEEF);
        check("rd_busy_T1", {63'h0, busy_o}, 64'h1);
        check("rd_if_rvalid_T1", {63'h0, if_rvalid_o}, 64'h0);
        tick();
        check("rd_rvalid_T2", {63'h0, dm_rvalid_o}, 64'h0);
        check("rd_rdata_T2", {32'h0, dm_rdata_o}, 64'h0);
        check("rd_busy_T2", {63'h0, busy_o}, 64'h0);
        $display("txn dm_read addr=0x104");

        // Partial write be=0010 to 0x200; inputs scrambled after grant
        dm_drive(1'b1, 4'b0010, 32'h200, 32'h0000AB00);
        #1;
        check("pw_gnt", {63'h0, dm_gnt_o}, 64'h1);
        check("pw_ram_we_T", {63'h0, ram_we_o}, 64'h0);
        check("pw_done_T", {63'h0, dm_done_o}, 64'h0);
        tick();
        idle_inputs();
        dm_be_i    = 4'b1111;
        dm_wdata_i = 32'hFFFFFFFF;
        #1;
        check("pw_done_T1", {63'h0, dm_done_o}, 64'h0);
        check("pw_ram_we_T1", {63'h0, ram_we_o}, 64'h0);
        check("pw_gnt_T1", {63'h0, dm_gnt_o}, 64'h0);
        tick();
        idle_inputs();
        #1;
        check("pw_ram_we_T2", {63'h0, ram_we_o}, 64'h1);
        check("pw_ram_wdata_T2", {32'h0, ram_wdata_o}, 64'h1122AB44);
        check("pw_ram_addr_T2", {32'h0, ram_addr_o}, 64'h200);
        check("pw_done_T2", {63'h0, dm_done_o}, 64'h1);
        tick();
        check("pw_done_T3", {63'h0, dm_done_o}, 64'h0);
        check("pw_mem", {32'h0, mem[32'h200 >> 2]}, 64'h1122AB44);
        check("pw_busy_T3", {63'h0, busy_o}, 64'h0);
        $display("txn dm_partial_write addr=0x200 be=0010");

        // Full write with a concurrent fetch request
        dm_drive(1'b1, 4'b1111, 32'h10, 32'hCAFEF00D);
        if_req_i  = 1'b1;
        if_addr_i = 32'h104;
        #1;
        check("fw_dm_gnt", {63'h0, dm_gnt_o}, 64'h1);
        check("fw_if_gnt", {63'h0, if_gnt_o}, 64'h0);
        check("fw_ram_we", {63'h0, ram_we_o}, 64'h1);
        check("fw_ram_wdata", {32'h0, ram_wdata_o}, 64'hCAFEF00D);
        check("fw_ram_addr", {32'h0, ram_addr_o}, 64'h10);
        check("fw_done", {63'h0, dm_done_o}, 64'h1);
        tick();
        dm_req_i = 1'b0;
        #1;
        check("fw_if_gnt_next", {63'h0, if_gnt_o}, 64'h1);
        check("fw_if_addr_next", {32'h0, ram_addr_o}, 64'h104);
        check("fw_done_next", {63'h0, dm_done_o}, 64'h0);
        tick();
        idle_inputs();
        #1;
        check("fw_if_rvalid", {63'h0, if_rvalid_o}, 64'h1);
        check("fw_if_rdata", {32'h0, if_rdata_o}, 64'hDEADBEEF);
        check("fw_dm_rvalid", {63'h0, dm_rvalid_o}, 64'h0);
        tick();
        check("fw_mem", {32'h0, mem[32'h10 >> 2]}, 64'hCAFEF00D);
        $display("txn dm_full_write addr=0x10 then if_read addr=0x104");

        // Both requesting: dm wins four times, then fetch
        dm_drive(1'b1, 4'b1111, 32'h40, 32'h12345678);
        if_req_i  = 1'b1;
        if_addr_i = 32'h200;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("st_dm_gnt_%0d", k), {62'h0, dm_gnt_o, if_gnt_o}, 64'h2);
            tick();
        end
        #1;
        check("st_if_gnt", {62'h0, dm_gnt_o, if_gnt_o}, 64'h1);
        tick();
        check("st_read_gnts", {62'h0, dm_gnt_o, if_gnt_o}, 64'h0);
        check("st_if_rdata", {32'h0, if_rdata_o}, 64'h1122AB44);
        tick();
        check("st_cleared_dm_gnt", {62'h0, dm_gnt_o, if_gnt_o}, 64'h2);
        idle_inputs();
        tick();
        $display("txn starvation if_granted_after_4_dm");

        // Empty byte enables: acknowledged with no RAM access
        dm_drive(1'b1, 4'b0000, 32'h200, 32'hFFFFFFFF);
        #1;
        check("be0_gnt_done", {62'h0, dm_gnt_o, dm_done_o}, 64'h3);
        check("be0_ram_we", {63'h0, ram_we_o}, 64'h0);
        tick();
        idle_inputs();
        #1;
        check("be0_done_after", {63'h0, dm_done_o}, 64'h0);
        check("be0_busy", {63'h0, busy_o}, 64'h0);
        check("be0_mem", {32'h0, mem[32'h200 >> 2]}, 64'h1122AB44);
        $display("txn dm_write be=0000");

        // Reset during RMW_READ
        dm_drive(1'b1, 4'b0001, 32'h300, 32'h000000AA);
        #1;
        check("rr_gnt", {63'h0, dm_gnt_o}, 64'h1);
        tick();
        idle_inputs();
        rst_i = 1'b1;
        #1;
        check("rr_ram_we_rst", {63'h0, ram_we_o}, 64'h0);
        tick();
        rst_i = 1'b0;
        #1;
        check("rr_busy", {63'h0, busy_o}, 64'h0);
        check("rr_ram_we", {63'h0, ram_we_o}, 64'h0);
        check("rr_done", {63'h0, dm_done_o}, 64'h0);
        tick();
        check("rr_mem", {32'h0, mem[32'h300 >> 2]}, 64'h55667788);
        $display("txn reset_in_rmw_read addr=0x300");

        // Reset during RMW_WRITE
        dm_drive(1'b1, 4'b0001, 32'h300, 32'h000000AA);
        tick();
        idle_inputs();
        tick();
        rst_i = 1'b1;
        #1;
        check("rw_ram_we_rst", {63'h0, ram_we_o}, 64'h0);
        check("rw_done_rst", {63'h0, dm_done_o}, 64'h0);
        tick();
        rst_i = 1'b0;
        #1;
        check("rw_busy", {63'h0, busy_o}, 64'h0);
        tick();
        check("rw_mem", {32'h0, mem[32'h300 >> 2]}, 64'h55667788);
        $display("txn reset_in_rmw_write addr=0x300");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
